hazard_controller: RTL

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller_pkg.sv | 15 +
 rtl/hazard_controller_forward.sv | 24 ++
 rtl/hazard_controller.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_controller_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_controller_forward.sv
// Operand forwarding select for one Execute-stage source register.
module forward_unit
    import hazard_controller_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic [ADDRESS_WIDTH-1:0] RsE,
    input  logic [ADDRESS_WIDTH-1:0] RdM,
    input  logic [ADDRESS_WIDTH-1:0] RdW,
    input  logic                     RegWriteM,
    input  logic                     RegWriteW,
    output logic [1:0]               Forward
);

    // Memory is the younger producer, so it wins over Writeback; x0 never forwards.
    always_comb begin
        Forward = FWD_RF;
        if (RegWriteM && (RdM != '0) && (RdM == RsE))
            Forward = FWD_MEM;
        else if (RegWriteW && (RdW != '0) && (RdW == RsE))
            Forward = FWD_WB;
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: forwarding, load-use/branch/memory-wait stalls and
// flushes, memory timeout detection and stall/flush performance counters.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH     = 32,
    parameter int TIMEOUT       = 255
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic [ADDRESS_WIDTH-1:0] Rs1D,
    input  logic [ADDRESS_WIDTH-1:0] Rs2D,
    input  logic [ADDRESS_WIDTH-1:0] Rs1E,
    input  logic [ADDRESS_WIDTH-1:0] Rs2E,
    input  logic [ADDRESS_WIDTH-1:0] RdE,
    input  logic [1:0]               ResultSrcE,
    input  logic                     PCSrcE,
    input  logic [ADDRESS_WIDTH-1:0] RdM,
    input  logic [ADDRESS_WIDTH-1:0] RdW,
    input  logic                     RegWriteM,
    input  logic                     RegWriteW,
    input  logic                     MemReqM,
    input  logic                     MemReadyM,
    input  logic                     CntClr,
    output logic                     StallF,
    output logic                     StallD,
    output logic                     StallE,
    output logic                     StallM,
    output logic                     FlushD,
    output logic                     FlushE,
    output logic                     FlushW,
    output logic [1:0]               ForwardAE,
    output logic [1:0]               ForwardBE,
    output logic                     MemErr,
    output logic [CNT_WIDTH-1:0]     StallCnt,
    output logic [CNT_WIDTH-1:0]     FlushCnt
);

    localparam int WW = $clog2(TIMEOUT + 2);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [WW-1:0]   wait_cnt;
    logic            load_use;
    logic            mem_stall;

    forward_unit #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd_a (
        .RsE       (Rs1E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .Forward   (ForwardAE)
    );

    forward_unit #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd_b (
        .RsE       (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .Forward   (ForwardBE)
    );

    assign load_use  = (ResultSrcE == RESULT_LOAD) && (RdE != '0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_stall = MemReqM && !MemReadyM;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (mem_stall) state_nxt = MEMWAIT;
            MEMWAIT: if (MemReadyM || !MemReqM) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Stall/flush decode is purely combinational on the inputs, independent of state.
    always_comb begin
        {StallF, StallD, StallE, StallM} = '0;
        {FlushD, FlushE, FlushW}         = '0;
        if (mem_stall) begin
            {StallF, StallD, StallE, StallM} = '1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // Holding the counter at zero throughout RUN gives the clear-on-entry behaviour.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wait_cnt <= '0;
            MemErr   <= 1'b0;
        end else begin
            if (state == RUN)
                wait_cnt <= '0;
            else if (mem_stall && (wait_cnt != WAIT_MAX))
                wait_cnt <= wait_cnt + 1'b1;

            if (CntClr)
                MemErr <= 1'b0;
            else if ((state == MEMWAIT) && mem_stall && (wait_cnt == WAIT_LAST))
                MemErr <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else if (CntClr) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallF) StallCnt <= StallCnt + CNT_WIDTH'(1);
            if (FlushE) FlushCnt <= FlushCnt + CNT_WIDTH'(1);
        end
    end

endmodule
